// File: rtl/clock_route_control_in_if.sv
// Handshake bundle between local control logic and the clock-route requester.
// master drives requests and the returned ack; slave is the requester block.
interface clock_route_control_in_if;
  logic req_enable;
  logic req_override;
  logic clear_error;
  logic async_enable0_ack;
  logic async_enable;
  logic async_override;
  logic route_enabled;
  logic busy;
  logic error;

  modport master (
    output req_enable, req_override, clear_error, async_enable0_ack,
    input  async_enable, async_override, route_enabled, busy, error
  );

  modport slave (
    input  req_enable, req_override, clear_error, async_enable0_ack,
    output async_enable, async_override, route_enabled, busy, error
  );
endinterface

// File: rtl/clock_route_control_in.sv
// Requester side of the clock-route enable handshake: four-phase enable/disable
// with a synchronized ack. Macro CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN adds the timeout/FAULT path.
module clock_route_control_in #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_W      = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic               clock,
  input logic               reset,
  clock_route_control_in_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLING,
    ST_ON,
    ST_DISABLING
`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic   override_q, override_d;
  logic   enable_q, route_q, busy_q, error_q;
  logic   sync_q [SYNC_STAGES];
  logic   ack_s;

  // Ack synchronizer chain; first stage is the only one touching the async input.
  always_ff @(posedge clock) begin
    if (reset) sync_q[0] <= 1'b0;
    else       sync_q[0] <= bus.async_enable0_ack;
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clock) begin
      if (reset) sync_q[gi] <= 1'b0;
      else       sync_q[gi] <= sync_q[gi-1];
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 timeout;

  assign timeout = (timer_q == TIMER_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.clear_error, TIMER_LAST};
`endif

  always_comb begin
    state_d    = state_q;
    override_d = override_q;
    case (state_q)
      ST_IDLE: begin
        override_d = bus.req_override;
        if (bus.req_enable) state_d = ST_ENABLING;
      end
      ST_ENABLING: begin
        // Ack wins over a coinciding timeout; req_enable only matters here at exit.
        if (ack_s) state_d = bus.req_enable ? ST_ON : ST_DISABLING;
`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
        else if (timeout) state_d = ST_FAULT;
`endif
      end
      ST_ON: begin
        if (!bus.req_enable) state_d = ST_DISABLING;
      end
      ST_DISABLING: begin
        if (!ack_s) state_d = ST_IDLE;
`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
        else if (timeout) state_d = ST_FAULT;
`endif
      end
`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
      ST_FAULT: begin
        if (bus.clear_error && !ack_s) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if ((state_q == ST_ENABLING || state_q == ST_DISABLING) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`endif

  // Outputs are registered decodes of the next state, so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      override_q <= 1'b0;
      enable_q   <= 1'b0;
      route_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      override_q <= override_d;
      enable_q   <= (state_d == ST_ENABLING) || (state_d == ST_ON);
      route_q    <= (state_d == ST_ON);
      busy_q     <= (state_d == ST_ENABLING) || (state_d == ST_DISABLING);
`ifdef CLOCK_ROUTE_CONTROL_IN_TIMEOUT_EN
      error_q    <= (state_d == ST_FAULT);
`else
      error_q    <= 1'b0;
`endif
    end
  end

  assign bus.async_enable   = enable_q;
  assign bus.async_override = override_q;
  assign bus.route_enabled  = route_q;
  assign bus.busy           = busy_q;
  assign bus.error          = error_q;

endmodule
